// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// slave is the loader's view; master is the source/memory side.
interface prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed, XOR-checksummed byte image -> 32-bit imem words.
// One-cycle registered write strobe per word; core released only after CSUM verifies.
module prog_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic           clk,
   input  logic           rst,
   prog_loader_if.slave   bus,
   output logic           core_rst,
   output logic           done,
   output logic           err
);
   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       asm_q, asm_d;
   logic [7:0]        xor_q, xor_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              core_rst_q, core_rst_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              in_ready;
   logic              xfer;
   logic [15:0]       n_full;

   assign in_ready = (state_q != S_RUN) && (state_q != S_ERR);
   assign xfer     = bus.in_valid && in_ready;
   assign n_full   = {bus.in_data, len_q[7:0]};

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      asm_d        = asm_q;
      xor_d        = xor_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      core_rst_d   = core_rst_q;
      done_d       = done_q;
      err_d        = err_q;
      if (xfer) begin
         xor_d = xor_q ^ bus.in_data;
         case (state_q)
            S_LEN0: begin
               len_d   = {8'h00, bus.in_data};
               state_d = S_LEN1;
            end
            S_LEN1: begin
               len_d = n_full;
               if (n_full == 16'd0 || {1'b0, n_full} > DEPTH_L) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d    = S_DATA;
                  word_cnt_d = 16'd0;
                  byte_cnt_d = 2'd0;
               end
            end
            S_DATA: begin
               // Bytes enter at the top so the first byte ends up in [7:0].
               asm_d      = {bus.in_data, asm_q[23:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                  imem_wdata_d = {bus.in_data, asm_q};
                  word_cnt_d   = word_cnt_q + 16'd1;
                  if (word_cnt_q + 16'd1 == len_q) begin
                     state_d = S_CSUM;
                  end
               end
            end
            S_CSUM: begin
               if ((xor_q ^ bus.in_data) == 8'h00) begin
                  state_d    = S_RUN;
                  core_rst_d = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_LEN0;
         len_q        <= '0;
         word_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         asm_q        <= '0;
         xor_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_rst_q   <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         xor_q        <= xor_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         core_rst_q   <= core_rst_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign core_rst       = core_rst_q;
   assign done           = done_q;
   assign err            = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random images against a byte-level image model.
module tb_prog_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic core_rst, done, err;

   prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst_n),
      .bus      (bus),
      .core_rst (core_rst),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   logic [7:0]  img[$];
   logic [31:0] wds[$];
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   bit          exp_ok;
   int          got_addr[$];
   logic [31:0] got_data[$];
   int          got_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         got_addr.push_back(int'(bus.imem_addr));
         got_data.push_back(bus.imem_wdata);
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("rst_we", bus.imem_we, 0);
      check("rst_addr", bus.imem_addr, 0);
      check("rst_wdata", bus.imem_wdata, 0);
      check("rst_core_rst", core_rst, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("rst_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic build_img(input bit bad);
      logic [15:0] n;
      logic [7:0]  x;
      img.delete();
      n = 16'(wds.size());
      img.push_back(n[7:0]);
      img.push_back(n[15:8]);
      foreach (wds[w]) for (int b = 0; b < 4; b++) img.push_back(wds[w][8*b +: 8]);
      x = 8'h00;
      foreach (img[i]) x ^= img[i];
      if (bad) x ^= 8'h01;
      img.push_back(x);
   endtask

   task automatic build_len(input logic [15:0] n);
      img.delete();
      img.push_back(n[7:0]);
      img.push_back(n[15:8]);
   endtask

   // Reference: interpret the byte image by the format rules alone.
   task automatic model_expect();
      int          n;
      logic [7:0]  x;
      exp_addr.delete();
      exp_data.delete();
      n = int'({img[1], img[0]});
      if (n == 0 || n > DEPTH) begin
         exp_ok = 1'b0;
      end else begin
         x = 8'h00;
         foreach (img[i]) x ^= img[i];
         exp_ok = (x == 8'h00);
         for (int w = 0; w < n; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({img[5+4*w], img[4+4*w], img[3+4*w], img[2+4*w]});
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      check("rdy", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   task automatic run_image(input string name, input int gap, input bit do_rst);
      int nw;
      if (do_rst) apply_reset();
      model_expect();
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      foreach (img[i]) begin
         if (i == img.size() - 1) begin
            check({name, "_pre_done"}, done, 0);
            check({name, "_pre_err"}, err, 0);
            check({name, "_pre_core"}, core_rst, 0);
         end
         send_byte(img[i], gap);
      end
      check({name, "_done"}, done, exp_ok);
      check({name, "_err"}, err, !exp_ok);
      check({name, "_core"}, core_rst, exp_ok);
      check({name, "_ready"}, bus.in_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      check({name, "_nwr"}, got_addr.size(), exp_addr.size());
      nw = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < nw; i++) begin
         check({name, "_addr"}, got_addr[i], exp_addr[i]);
         check({name, "_data"}, got_data[i], exp_data[i]);
         if (gap == 0 && i > 0) check({name, "_spacing"}, got_cyc[i] - got_cyc[i-1], 4);
      end
      check({name, "_hold_done"}, done, exp_ok);
      check({name, "_hold_err"}, err, !exp_ok);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #2;

      wds = '{32'h00000013, 32'h00A00093};
      build_img(1'b0);
      run_image("basic", 0, 1'b1);

      build_img(1'b1);
      run_image("badsum", 0, 1'b1);

      build_len(16'd0);
      run_image("len0", 0, 1'b1);

      build_len(16'(DEPTH + 1));
      run_image("lenbig", 0, 1'b1);

      wds = '{32'hC0FFEE42};
      build_img(1'b0);
      run_image("gapped", 3, 1'b1);

      wds.delete();
      for (int i = 0; i < DEPTH; i++) wds.push_back(32'(i));
      build_img(1'b0);
      run_image("full", 0, 1'b1);

      apply_reset();
      wds = '{32'hDEADBEEF, 32'h12345678, 32'h0BADF00D};
      build_img(1'b0);
      for (int i = 0; i < 8; i++) send_byte(img[i], 0);
      rst_n = 1'b0;
      #1;
      check("mid_we", bus.imem_we, 0);
      check("mid_addr", bus.imem_addr, 0);
      check("mid_wdata", bus.imem_wdata, 0);
      check("mid_core", core_rst, 0);
      check("mid_done", done, 0);
      check("mid_err", err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      wds = '{32'(($urandom))};
      build_img(1'b0);
      run_image("after_mid", 0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         int n;
         n = $urandom_range(1, 6);
         wds.delete();
         for (int w = 0; w < n; w++) wds.push_back(32'($urandom));
         build_img($urandom_range(0, 3) == 0);
         run_image("rand", $urandom_range(0, 2), 1'b1);
      end

      apply_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits between a byte-stream source (test bench, debug port) and the pipeline's instruction memory. It receives a length-prefixed, checksummed program image one byte at a time and writes it into instruction memory as 32-bit words. It holds the pipeline in reset until the whole image has been received and verified, then drives `core_rst` high to release the core.

## Interface
Parameters:
- `ADDR_W`, 10: instruction-memory word-address width.
- `DEPTH`, 1024: maximum number of words accepted; must be ≤ 2^ADDR_W.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: source presents a byte.
- `in_data`, in, 8: byte value.
- `in_ready`, out, 1: loader accepts a byte; a transfer occurs when `in_valid` and `in_ready` are both high at a rising edge.
- `imem_we`, out, 1: one-cycle instruction-memory write strobe.
- `imem_addr`, out, ADDR_W: word address of the write.
- `imem_wdata`, out, 32: word to write.
- `core_rst`, out, 1: active-low reset to the pipeline; 0 until the image is verified.
- `done`, out, 1: image loaded and verified (sticky).
- `err`, out, 1: image rejected (sticky).

## Operation
- Image format, little-endian: LEN0, LEN1 (16-bit word count N), then 4·N data bytes, then CSUM.
- Each group of 4 data bytes forms one word, first byte in bits [7:0].
- CSUM is chosen so that the XOR of every image byte, including LEN0, LEN1 and CSUM, equals 0x00.
- States: `S_LEN0`, `S_LEN1`, `S_DATA`, `S_CSUM`, `S_RUN`, `S_ERR`.
- `S_LEN0`: on a transfer, store the low byte of N and go to `S_LEN1`.
- `S_LEN1`: on a transfer, form N.
  - N == 0 or N > DEPTH: go to `S_ERR`.
  - Otherwise: go to `S_DATA` with word counter = 0 and byte counter = 0.
- `S_DATA`: on each transfer, shift the byte into the assembly register.
  - On the 4th byte, register the write: `imem_addr` = word counter, `imem_wdata` = assembled word, `imem_we` = 1 for the next cycle only. Then increment the word counter and clear the byte counter.
  - After the 4th byte of word N−1, go to `S_CSUM`.
- `S_CSUM`: on a transfer, check the running XOR.
  - XOR == 0: go to `S_RUN`.
  - Otherwise: go to `S_ERR`.
- `S_RUN`: `core_rst` = 1, `done` = 1, `in_ready` = 0. Terminal until reset.
- `S_ERR`: `err` = 1, `core_rst` = 0, `in_ready` = 0. Terminal until reset.
- `in_ready` = 1 in `S_LEN0`, `S_LEN1`, `S_DATA` and `S_CSUM`. No back-pressure during word writes.
- Any number of idle cycles (`in_valid` = 0) may occur between bytes; state and counters hold.
- Already-written words are not erased on error.

## Timing
- Reset values, applied asynchronously while `rst` = 0:
  - state = `S_LEN0`.
  - `in_ready` = 1 after release; combinational from state.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `core_rst` = 0, `done` = 0, `err` = 0.
  - All counters and the XOR accumulator = 0.
- Write latency: `imem_we` is high in the cycle immediately after the edge that accepted a word's 4th byte. `imem_addr` and `imem_wdata` are valid in that same cycle.
- Back-to-back words on consecutive cycles give `imem_we` pulses 4 cycles apart.
- `core_rst`, `done` and `err` are registered. They rise one cycle after the edge that accepted CSUM, or LEN1 in the length-error case.
- The transfer of the final data byte and the CSUM transfer may be in consecutive cycles.
- Reset asserted mid-image: all outputs return to reset values immediately and `core_rst` falls to 0 even from `S_RUN`. The next image starts again at LEN0.
- The word counter never exceeds DEPTH; addresses do not wrap.

## Test plan
- Basic load: N = 2, words 0x00000013 and 0x00A00093, correct CSUM.
  - Required: `imem_we` pulses at addr 0 then addr 1 with those data.
  - One cycle after CSUM: `core_rst` = 1, `done` = 1, `in_ready` = 0.
- Bad checksum: same image with CSUM XOR 0x01.
  - Required: both words are written, then `err` = 1, `core_rst` stays 0, `done` stays 0.
- Length errors:
  - N = 0: `err` = 1 one cycle after LEN1; no `imem_we` pulse.
  - N = DEPTH+1: same response.
- Gapped stream: N = 1 with 3 idle cycles between every byte.
  - Required: a single `imem_we` at addr 0 with the correct word; `done` = 1.
- Full depth: N = DEPTH with word i = i.
  - Required: DEPTH writes, the last at addr DEPTH−1 with data DEPTH−1; then `done` = 1.
- Reset mid-load: assert `rst` = 0 after 6 data bytes, release, then send a valid N = 1 image.
  - Required: all outputs return to 0 immediately.
  - The second image writes addr 0 and reaches `done` = 1.
